// File: rtl/mem_access_unit_if.sv
// Bundle of the core request channel and the word-addressed Memory channel
// used by mem_access_unit. The master side is the environment (core plus
// Memory); the slave side is the load/store unit itself.
interface mem_access_unit_if;
    // core request / completion
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_done;
    logic        req_fault;
    logic [31:0] resp_data;
    // Memory write channel
    logic [31:0] mem_in_addr;
    logic [31:0] mem_in_data;
    logic        mem_in_valid;
    logic        mem_in_ready;
    // Memory read channel
    logic [31:0] mem_out_addr;
    logic        mem_out_valid;
    logic        mem_out_ready;
    logic [31:0] mem_out_data;
    logic        mem_addr_error;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_done, req_fault, resp_data,
        input  mem_in_addr, mem_in_data, mem_in_valid,
        output mem_in_ready,
        input  mem_out_addr, mem_out_valid,
        output mem_out_ready, mem_out_data, mem_addr_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_done, req_fault, resp_data,
        output mem_in_addr, mem_in_data, mem_in_valid,
        input  mem_in_ready,
        output mem_out_addr, mem_out_valid,
        input  mem_out_ready, mem_out_data, mem_addr_error
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-addressed Memory. Checks alignment, turns
// byte/half/word accesses into Memory reads and writes (sub-word stores are
// read-modify-write), extracts and extends load data, and reports a single
// completion pulse with a fault flag.
module mem_access_unit (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic        write_r;
    logic [31:0] write_word_r;
    logic [31:0] resp_data_r;
    logic        req_done_r;
    logic        req_fault_r;
    logic        mem_in_valid_r;
    logic        mem_out_valid_r;
    logic        misaligned_s;

    // Extract the addressed little-endian lane and extend it to 32 bits.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {off, 3'b000};
        case (size)
            2'd0:    result = {{24{sgn & shifted[7]}}, shifted[7:0]};
            2'd1:    result = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

    // Replace only the addressed lane of the read word with the store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic [31:0] data
    );
        logic [31:0] mask;
        logic [31:0] ins;
        case (size)
            2'd0:    mask = 32'h0000_00ff << {off, 3'b000};
            2'd1:    mask = 32'h0000_ffff << {off, 3'b000};
            default: mask = 32'hffff_ffff;
        endcase
        ins = (data << {off, 3'b000}) & mask;
        return (word & ~mask) | ins;
    endfunction

    // Alignment / legal-size check of the incoming request.
    always_comb begin
        misaligned_s = 1'b0;
        case (bus.req_size)
            2'd0:    misaligned_s = 1'b0;
            2'd1:    misaligned_s = bus.req_addr[0];
            2'd2:    misaligned_s = (bus.req_addr[1:0] != 2'b00);
            default: misaligned_s = 1'b1;
        endcase
    end

    // Access sequencer: state plus every registered output moves in lockstep,
    // so Memory valids are a pure function of the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            addr_r          <= 32'd0;
            wdata_r         <= 32'd0;
            size_r          <= 2'd0;
            signed_r        <= 1'b0;
            write_r         <= 1'b0;
            write_word_r    <= 32'd0;
            resp_data_r     <= 32'd0;
            req_done_r      <= 1'b0;
            req_fault_r     <= 1'b0;
            mem_in_valid_r  <= 1'b0;
            mem_out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    req_done_r      <= 1'b0;
                    req_fault_r     <= 1'b0;
                    resp_data_r     <= 32'd0;
                    mem_in_valid_r  <= 1'b0;
                    mem_out_valid_r <= 1'b0;
                    if (bus.req_valid) begin
                        addr_r   <= bus.req_addr;
                        wdata_r  <= bus.req_wdata;
                        size_r   <= bus.req_size;
                        signed_r <= bus.req_signed;
                        write_r  <= bus.req_write;
                        if (misaligned_s) begin
                            state_r     <= FAULT;
                            req_done_r  <= 1'b1;
                            req_fault_r <= 1'b1;
                        end else if (!bus.req_write || (bus.req_size != 2'd2)) begin
                            state_r         <= READ;
                            mem_out_valid_r <= 1'b1;
                        end else begin
                            state_r        <= WRITE;
                            mem_in_valid_r <= 1'b1;
                            write_word_r   <= bus.req_wdata;
                        end
                    end
                end
                READ: begin
                    if (bus.mem_out_ready) begin
                        mem_out_valid_r <= 1'b0;
                        if (bus.mem_addr_error) begin
                            state_r     <= FAULT;
                            req_done_r  <= 1'b1;
                            req_fault_r <= 1'b1;
                            resp_data_r <= 32'd0;
                        end else if (!write_r) begin
                            state_r     <= DONE;
                            req_done_r  <= 1'b1;
                            resp_data_r <= load_extract(bus.mem_out_data, addr_r[1:0],
                                                        size_r, signed_r);
                        end else begin
                            state_r        <= WRITE;
                            mem_in_valid_r <= 1'b1;
                            write_word_r   <= store_merge(bus.mem_out_data, addr_r[1:0],
                                                          size_r, wdata_r);
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_in_ready) begin
                        mem_in_valid_r <= 1'b0;
                        req_done_r     <= 1'b1;
                        resp_data_r    <= 32'd0;
                        if (bus.mem_addr_error) begin
                            state_r     <= FAULT;
                            req_fault_r <= 1'b1;
                        end else begin
                            state_r <= DONE;
                        end
                    end
                end
                DONE, FAULT: begin
                    // One-cycle completion; the next request is only looked at
                    // from IDLE, so the still-held req_valid is not re-issued.
                    state_r     <= IDLE;
                    req_done_r  <= 1'b0;
                    req_fault_r <= 1'b0;
                    resp_data_r <= 32'd0;
                end
                default: begin
                    state_r         <= IDLE;
                    req_done_r      <= 1'b0;
                    req_fault_r     <= 1'b0;
                    resp_data_r     <= 32'd0;
                    mem_in_valid_r  <= 1'b0;
                    mem_out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_done      = req_done_r;
    assign bus.req_fault     = req_fault_r;
    assign bus.resp_data     = resp_data_r;
    assign bus.mem_out_valid = mem_out_valid_r;
    assign bus.mem_out_addr  = {addr_r[31:2], 2'b00};
    assign bus.mem_in_valid  = mem_in_valid_r;
    assign bus.mem_in_addr   = {addr_r[31:2], 2'b00};
    assign bus.mem_in_data   = write_word_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan steps followed
// by random accesses, checked against a byte-array reference model.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- Memory stub: 32 words, answers one cycle after valid
    logic [31:0] mem_word [0:31];
    logic        mem_init_done = 1'b0;
    int          rd_count = 0;
    int          wr_count = 0;
    logic        overlap_seen = 1'b0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;

    always @(posedge clk) begin
        bus.mem_out_ready  <= 1'b0;
        bus.mem_in_ready   <= 1'b0;
        bus.mem_addr_error <= 1'b0;
        if (!mem_init_done) begin
            for (int i = 0; i < 32; i++)
                mem_word[i] <= (i * 32'h9e37_79b9) ^ 32'h5a5a_5a5a;
            mem_init_done <= 1'b1;
        end else if (bus.mem_out_valid && !bus.mem_out_ready) begin
            bus.mem_out_ready  <= 1'b1;
            bus.mem_addr_error <= (bus.mem_out_addr[31:2] >= 30'd32);
            bus.mem_out_data   <= (bus.mem_out_addr[31:2] >= 30'd32) ? 32'hdead_beef
                                  : mem_word[bus.mem_out_addr[6:2]];
        end else if (bus.mem_in_valid && !bus.mem_in_ready) begin
            bus.mem_in_ready   <= 1'b1;
            bus.mem_addr_error <= (bus.mem_in_addr[31:2] >= 30'd32);
            if (bus.mem_in_addr[31:2] < 30'd32)
                mem_word[bus.mem_in_addr[6:2]] <= bus.mem_in_data;
        end
    end

    // Transaction monitor: counts Memory requests and flags simultaneous valids.
    always @(posedge clk) begin
        prev_rd <= bus.mem_out_valid;
        prev_wr <= bus.mem_in_valid;
        if (bus.mem_out_valid && !prev_rd) rd_count <= rd_count + 1;
        if (bus.mem_in_valid && !prev_wr)  wr_count <= wr_count + 1;
        if (bus.mem_out_valid && bus.mem_in_valid) overlap_seen <= 1'b1;
    end

    // ---------------- Reference model: plain byte array
    logic [7:0] ref_mem [0:127];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic sgn);
        logic [31:0] v;
        int n;
        n = nbytes(size);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + 32'(i)]) << (8 * i));
        if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hffff_ffff << (8 * n));
        return v;
    endfunction

    // Drive one request and wait for its completion.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output int lat, output logic flt, output logic [31:0] data,
                             output int rd, output int wr);
        int rd0, wr0;
        rd0 = rd_count;
        wr0 = wr_count;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        lat  = -1;
        flt  = 1'b0;
        data = 32'd0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.req_done) begin
                lat  = c;
                flt  = bus.req_fault;
                data = bus.resp_data;
                break;
            end
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd = rd_count - rd0;
        wr = wr_count - wr0;
    endtask

    // Run one access and compare against the reference model.
    task automatic access_check(input string tag, input logic w, input logic [1:0] sz,
                                input logic sg, input logic [31:0] addr,
                                input logic [31:0] wd);
        int lat, rd, wr, exp_lat, exp_rd, exp_wr;
        logic flt, exp_flt, misal, oob;
        logic [31:0] data, exp_data;
        do_access(w, sz, sg, addr, wd, lat, flt, data, rd, wr);
        misal = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
        oob   = (addr >= 32'd128);
        exp_flt  = misal || oob;
        exp_data = (w || exp_flt) ? 32'd0 : ref_load(addr, sz, sg);
        exp_rd   = (misal || (w && sz == 2'd2)) ? 0 : 1;
        exp_wr   = (misal || !w || (oob && sz != 2'd2)) ? 0 : 1;
        if (misal)                  exp_lat = 1;
        else if (oob)               exp_lat = 3;
        else if (w && sz != 2'd2)   exp_lat = 5;
        else                        exp_lat = 3;
        check({tag, ".lat"},   32'(lat), 32'(exp_lat));
        check({tag, ".fault"}, {31'd0, flt}, {31'd0, exp_flt});
        check({tag, ".data"},  data, exp_data);
        check({tag, ".reads"}, 32'(rd), 32'(exp_rd));
        check({tag, ".writes"}, 32'(wr), 32'(exp_wr));
        if (w && !exp_flt)
            for (int i = 0; i < nbytes(sz); i++) ref_mem[addr + 32'(i)] = wd[8 * i +: 8];
    endtask

    initial begin
        logic [31:0] init_word;
        logic [31:0] a;
        logic [1:0]  s;
        int          rd_before;
        logic        done_seen;

        for (int i = 0; i < 32; i++) begin
            init_word = (i * 32'h9e37_79b9) ^ 32'h5a5a_5a5a;
            for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = init_word[8 * b +: 8];
        end
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.done",  {31'd0, bus.req_done},      32'd0);
        check("rst.fault", {31'd0, bus.req_fault},     32'd0);
        check("rst.data",  bus.resp_data,              32'd0);
        check("rst.ivld",  {31'd0, bus.mem_in_valid},  32'd0);
        check("rst.ovld",  {31'd0, bus.mem_out_valid}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // word store / load round trip
        access_check("wst36", 1'b1, 2'd2, 1'b0, 32'd36, 32'hefef_efef);
        access_check("wld36", 1'b0, 2'd2, 1'b0, 32'd36, 32'd0);
        check("wld36.val", ref_load(32'd36, 2'd2, 1'b0), 32'hefef_efef);
        // sign/zero extension
        access_check("wst40", 1'b1, 2'd2, 1'b0, 32'd40, 32'h80c3_f10a);
        access_check("lb41s", 1'b0, 2'd0, 1'b1, 32'd41, 32'd0);
        access_check("lb41u", 1'b0, 2'd0, 1'b0, 32'd41, 32'd0);
        access_check("lh42s", 1'b0, 2'd1, 1'b1, 32'd42, 32'd0);
        // read-modify-write sub-word stores
        access_check("wst16", 1'b1, 2'd2, 1'b0, 32'd16, 32'h1122_3344);
        access_check("sb19",  1'b1, 2'd0, 1'b0, 32'd19, 32'h0000_00aa);
        access_check("sh16",  1'b1, 2'd1, 1'b0, 32'd16, 32'h0000_5566);
        access_check("wld16", 1'b0, 2'd2, 1'b0, 32'd16, 32'd0);
        check("wld16.val", ref_load(32'd16, 2'd2, 1'b0), 32'haa22_5566);
        // alignment / size faults
        access_check("mis_w22", 1'b0, 2'd2, 1'b0, 32'h22, 32'd0);
        access_check("mis_h11", 1'b1, 2'd1, 1'b0, 32'h11, 32'h1234);
        access_check("size3",   1'b0, 2'd3, 1'b0, 32'h0,  32'd0);
        // Memory address error and last valid byte
        access_check("oob128",  1'b0, 2'd2, 1'b0, 32'd128, 32'd0);
        access_check("sb127",   1'b1, 2'd0, 1'b0, 32'd127, 32'h0000_0077);
        access_check("lb127",   1'b0, 2'd0, 1'b0, 32'd127, 32'd0);

        // reset while a read is outstanding
        rd_before = rd_count;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_addr = 32'd36;
        @(posedge clk); #1;
        check("mid.ovld", {31'd0, bus.mem_out_valid}, 32'd1);
        reset = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid.done",  {31'd0, bus.req_done},      32'd0);
        check("mid.fault", {31'd0, bus.req_fault},     32'd0);
        check("mid.data",  bus.resp_data,              32'd0);
        check("mid.ivld",  {31'd0, bus.mem_in_valid},  32'd0);
        check("mid.ovld0", {31'd0, bus.mem_out_valid}, 32'd0);
        reset = 1'b0;
        done_seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.req_done) done_seen = 1'b1;
        end
        check("mid.nodone", {31'd0, done_seen}, 32'd0);
        check("mid.reads", 32'(rd_count - rd_before), 32'd1);
        access_check("post_wld36", 1'b0, 2'd2, 1'b0, 32'd36, 32'd0);

        // random accesses
        for (int n = 0; n < 60; n++) begin
            s = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 159));
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'd1) a[0] = 1'b0;
                if (s == 2'd2) a[1:0] = 2'b00;
            end
            access_check($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), s,
                         1'($urandom_range(0, 1)), a, $urandom);
        end

        check("no_overlap", {31'd0, overlap_seen}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
